// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl -- pointer/flag controller for a 2**ADDR_WIDTH entry FIFO built
// around an external single-port-write / async-read 8-bit RAM of the same
// address width. The controller never touches data; it only steers the RAM
// write strobe and both addresses, and tracks occupancy.
//
// Parameters
//   ADDR_WIDTH  RAM address width; FIFO depth is 2**ADDR_WIDTH entries.
//
// Ports
//   clk        in   sole clock, all state updates on the rising edge
//   reset      in   synchronous, active-high reset
//   wr         in   push request from the producer
//   rd         in   pop request from the consumer
//   wr_en      out  RAM write strobe (combinational, equals accepted push)
//   w_addr     out  write pointer, drives RAM write address
//   r_addr     out  read pointer, drives RAM read address; RAM read data is
//                   the head entry whenever empty is low
//   full       out  FIFO holds 2**ADDR_WIDTH entries (registered)
//   empty      out  FIFO holds no entries (registered)
//   count      out  number of stored entries, 0..2**ADDR_WIDTH (registered)
//   overflow   out  sticky: push attempted while full without a pop
//   underflow  out  sticky: pop attempted while empty without a push
//
// Build option
//   FIFO_CTRL_ERR_EN  when defined, adds the overflow/underflow ports and
//                     their sticky error logic; when undefined they are
//                     absent and all other behaviour is identical.
// ---------------------------------------------------------------------------
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int                  DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  // Accepted transfers. A push while full is only legal when a pop frees the
  // head slot in the same cycle (RAM reads the old head, then the new data
  // lands in that slot at the edge). Reset blocks both so wr_en stays low.
  logic push;
  logic pop;

  assign push  = wr & (~full | rd) & ~reset;
  assign pop   = rd & ~empty & ~reset;
  assign wr_en = push;

  // Next-state values.
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [ADDR_WIDTH-1:0] r_addr_next;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  full_next;
  logic                  empty_next;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_addr_next = w_addr;
    r_addr_next = r_addr;
    count_next  = count;
    full_next   = full;
    empty_next  = empty;

    // Pointers wrap naturally at 2**ADDR_WIDTH through truncation.
    if (push) w_addr_next = w_addr + PTR_ONE;
    if (pop)  r_addr_next = r_addr + PTR_ONE;

    unique case ({push, pop})
      2'b10: begin
        count_next = count + CNT_ONE;
        empty_next = 1'b0;
        // Write pointer catching up with the read pointer means full.
        full_next  = (w_addr_next == r_addr);
      end
      2'b01: begin
        count_next = count - CNT_ONE;
        full_next  = 1'b0;
        // Read pointer catching up with the write pointer means empty.
        empty_next = (r_addr_next == w_addr);
      end
      // Simultaneous push and pop (including the full case) leaves the
      // occupancy and flags untouched; no transfer changes nothing.
      default: ;
    endcase
  end

  // Flags and occupancy are registered straight from the next-state logic,
  // so there is no combinational path from wr/rd to full, empty or count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      w_addr <= '0;
      r_addr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      w_addr <= w_addr_next;
      r_addr <= r_addr_next;
      count  <= count_next;
      full   <= full_next;
      empty  <= empty_next;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  // Sticky error flags. A pop while empty that is paired with a push is a
  // plain write, not an underflow; a push while full paired with a pop is a
  // legal replace, not an overflow. The RAM itself is never cleared: reset
  // only discards contents logically by resetting the pointers.
  logic overflow_set;
  logic underflow_set;

  assign overflow_set  = wr & full  & ~rd;
  assign underflow_set = rd & empty & ~wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | overflow_set;
      underflow <= underflow | underflow_set;
    end
  end
`endif

  // Structural invariants of the pointer/occupancy bookkeeping.
  a_flags_exclusive : assert property (
    @(posedge clk) disable iff (reset) !(full && empty));

  a_count_matches_ptrs : assert property (
    @(posedge clk) disable iff (reset)
      full ? (count == CNT_FULL)
           : (count == {1'b0, (w_addr - r_addr)}));

  a_empty_means_zero : assert property (
    @(posedge clk) disable iff (reset) empty == (count == '0));

  a_no_write_in_reset : assert property (
    @(posedge clk) reset |-> !wr_en);

endmodule

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl -- directed, table-driven bench for fifo_ctrl (ADDR_WIDTH=3).
// A small 8-bit RAM model is hooked to the controller's strobe and addresses
// so the hand-written sequences can follow data through the FIFO.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr;
  logic          rd;
  logic          wr_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
`ifdef FIFO_CTRL_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (rd),
    .wr_en  (wr_en),
    .w_addr (w_addr),
    .r_addr (r_addr),
    .full   (full),
    .empty  (empty),
    .count  (count)
`ifdef FIFO_CTRL_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: write on the edge when strobed, asynchronous read.
  logic [7:0] mem [8];
  logic [7:0] wdata;
  logic [7:0] rd_data;

  always_ff @(posedge clk) if (wr_en) mem[w_addr] <= wdata;
  assign rd_data = mem[r_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge, then let them settle.
  task automatic apply(input logic r, input logic w, input logic p, input logic [7:0] d);
    @(negedge clk);
    reset = r; wr = w; rd = p; wdata = d;
    #1;
  endtask

  // Step through the next rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, w, r;      // stimulus
    logic        wen;            // expected wr_en before the edge
    logic [2:0]  wa, ra;         // expected pointers after the edge
    logic        f, e;           // expected flags after the edge
    logic [3:0]  cnt;            // expected count after the edge
    logic        ov, un;         // expected sticky errors after the edge
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  task automatic add(input logic rst, input logic w, input logic r, input logic wen,
                     input int wa, input int ra, input logic f, input logic e,
                     input int cnt, input logic ov, input logic un);
    vecs[nvec].rst = rst; vecs[nvec].w = w; vecs[nvec].r = r; vecs[nvec].wen = wen;
    vecs[nvec].wa = 3'(wa); vecs[nvec].ra = 3'(ra);
    vecs[nvec].f = f; vecs[nvec].e = e; vecs[nvec].cnt = 4'(cnt);
    vecs[nvec].ov = ov; vecs[nvec].un = un;
    nvec++;
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; wdata = 8'h00;

    // ---------------- vector table ----------------
    //   rst w r  wen  wa   ra   f  e  cnt ov un
    add(1, 0, 0,  0,   0,   0,   0, 1, 0,  0, 0);              // reset
    for (int i = 1; i <= 8; i++)                               // 8 pushes
      add(0, 1, 0, 1, i % 8, 0, (i == 8), 0, i, 0, 0);
    add(0, 1, 0,  0,   0,   0,   1, 0, 8,  1, 0);              // push while full
    for (int i = 1; i <= 8; i++)                               // 8 pops
      add(0, 0, 1, 0, 0, i % 8, 0, (i == 8), 8 - i, 1, 0);
    add(0, 0, 1,  0,   0,   0,   0, 1, 0,  1, 1);              // pop while empty
    add(1, 0, 0,  0,   0,   0,   0, 1, 0,  0, 0);              // reset clears
    add(0, 1, 1,  1,   1,   0,   0, 0, 1,  0, 0);              // wr&rd on empty
    for (int i = 2; i <= 4; i++)                               // fill to 4
      add(0, 1, 0, 1, i, 0, 0, 0, i, 0, 0);
    add(0, 1, 1,  1,   5,   1,   0, 0, 4,  0, 0);              // wr&rd mid-fill
    add(1, 1, 0,  0,   0,   0,   0, 1, 0,  0, 0);              // reset beats wr

    for (int k = 0; k < nvec; k++) begin
      apply(vecs[k].rst, vecs[k].w, vecs[k].r, 8'(k));
      check($sformatf("v%0d wr_en", k), 32'(wr_en), 32'(vecs[k].wen));
      tick();
      check($sformatf("v%0d w_addr", k), 32'(w_addr), 32'(vecs[k].wa));
      check($sformatf("v%0d r_addr", k), 32'(r_addr), 32'(vecs[k].ra));
      check($sformatf("v%0d full", k),   32'(full),   32'(vecs[k].f));
      check($sformatf("v%0d empty", k),  32'(empty),  32'(vecs[k].e));
      check($sformatf("v%0d count", k),  32'(count),  32'(vecs[k].cnt));
`ifdef FIFO_CTRL_ERR_EN
      check($sformatf("v%0d overflow", k),  32'(overflow),  32'(vecs[k].ov));
      check($sformatf("v%0d underflow", k), 32'(underflow), 32'(vecs[k].un));
`endif
    end

    // ---------------- data ordering through the RAM ----------------
    apply(1, 0, 0, 8'h00); tick();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 8'(8'h10 + i)); tick();
    end
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 8'h00);
      check($sformatf("fifo order head %0d", i), 32'(rd_data), 32'(8'h10 + i));
      tick();
    end
    check("drained empty",  32'(empty),  32'(1'b1));
    check("drained w_addr", 32'(w_addr), 32'd5);
    check("drained r_addr", 32'(r_addr), 32'd5);

    // ---------------- full at 5/5, simultaneous push+pop ----------------
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 0, 8'(8'h20 + i)); tick();
    end
    check("5/5 full",  32'(full),  32'(1'b1));
    check("5/5 count", 32'(count), 32'd8);
    check("5/5 w_addr", 32'(w_addr), 32'd5);
    check("5/5 r_addr", 32'(r_addr), 32'd5);

    apply(0, 1, 1, 8'h99);
    check("replace wr_en",    32'(wr_en),   32'(1'b1));
    check("replace old head", 32'(rd_data), 32'h20);
    tick();
    check("replace w_addr",   32'(w_addr),  32'd6);
    check("replace r_addr",   32'(r_addr),  32'd6);
    check("replace full",     32'(full),    32'(1'b1));
    check("replace empty",    32'(empty),   32'(1'b0));
    check("replace count",    32'(count),   32'd8);
    check("replace slot5",    32'(mem[5]),  32'h99);
    check("replace new head", 32'(rd_data), 32'h21);

    // ---------------- pop while empty paired with push ----------------
    apply(1, 0, 0, 8'h00); tick();
    apply(0, 1, 1, 8'h5a);
    check("empty wr&rd wr_en", 32'(wr_en), 32'(1'b1));
    tick();
    check("empty wr&rd r_addr", 32'(r_addr), 32'd0);
    check("empty wr&rd head",   32'(rd_data), 32'h5a);
`ifdef FIFO_CTRL_ERR_EN
    check("empty wr&rd underflow", 32'(underflow), 32'(1'b0));
`endif

    apply(0, 0, 0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
